// File: rtl/axis_demux_pkt_pkg.sv
// Shared definitions for the packet-locked AXI-Stream demultiplexer.
package axis_demux_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int unsigned SEL_EN_BIT = 7;
  localparam int unsigned SEL_IDX_W  = 7;

  // Channel index width; a single-channel build still carries one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_demux_pkt_if.sv
// AXI-Stream bundle; N lanes share one interface (N=1 for the upstream side).
interface axis_demux_pkt_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned DATA_W = 32
);
  logic [N*DATA_W-1:0] tdata;
  logic [N-1:0]        tvalid;
  logic [N-1:0]        tlast;
  logic [N-1:0]        tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry (main + skid) pipeline buffer with a registered upstream ready.
module axis_skid_buf #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 out_ready,
  output logic                 occupied
);

  logic                 main_v, main_v_n;
  logic                 skid_v, skid_v_n;
  logic [PAYLOAD_W-1:0] main_q, main_n;
  logic [PAYLOAD_W-1:0] skid_q, skid_n;
  logic                 rdy_q;
  logic                 consume;

  assign consume     = main_v & out_ready;
  assign out_valid   = main_v;
  assign out_payload = main_q;
  assign in_ready    = rdy_q;
  assign occupied    = main_v | skid_v;

  // in_valid is only ever raised while rdy_q=1, i.e. while the skid is empty.
  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    main_n   = main_q;
    skid_n   = skid_q;
    if (skid_v) begin
      if (consume) begin
        main_n   = skid_q;
        skid_v_n = 1'b0;
      end
    end else if (!main_v || consume) begin
      main_v_n = in_valid;
      if (in_valid) main_n = in_payload;
    end else if (in_valid) begin
      skid_v_n = 1'b1;
      skid_n   = in_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      main_q <= main_n;
      skid_q <= skid_n;
      rdy_q  <= ~skid_v_n;
    end
  end

endmodule

// File: rtl/axis_demux_pkt.sv
// Packet-locked AXI-Stream demultiplexer: the route select is sampled on a
// packet's first beat and held until tlast; invalid selects drop or stall.
module axis_demux_pkt
  import axis_demux_pkt_pkg::*;
#(
  parameter int unsigned NUM_CH       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter bit          DROP_INVALID = 1'b1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [7:0]             bus_sel,
  axis_demux_pkt_if.slave        s_axis,
  axis_demux_pkt_if.master       m_axis,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);

  localparam int unsigned CH_W  = ch_width(NUM_CH);
  localparam int unsigned PAY_W = DATA_W + 1 + CH_W;

  state_t              state, state_n;
  logic [CH_W-1:0]     ch_q, ch_n, fwd_ch;
  logic [SEL_IDX_W-1:0] sel_idx;
  logic                sel_ok, stall, accept, fwd, drop_inc;
  logic                buf_ready, buf_occupied;
  logic                out_valid, out_ready;
  logic [PAY_W-1:0]    in_payload, out_payload;
  logic [CH_W-1:0]     main_ch;
  logic                main_last;
  logic [DATA_W-1:0]   main_data;
  logic [NUM_CH-1:0]   m_valid, m_last;
  logic [NUM_CH*DATA_W-1:0] m_data;

  assign sel_idx = bus_sel[SEL_IDX_W-1:0];
  assign sel_ok  = bus_sel[SEL_EN_BIT] && (32'(sel_idx) < NUM_CH);
  // Stall gating is combinational on bus_sel so a newly valid select is honoured at once.
  assign stall   = !DROP_INVALID && (state == ST_IDLE) && !sel_ok;
  assign s_axis.tready = buf_ready & ~stall;
  assign accept  = s_axis.tvalid[0] & buf_ready & ~stall;

  always_comb begin
    state_n  = state;
    ch_n     = ch_q;
    fwd      = 1'b0;
    fwd_ch   = ch_q;
    drop_inc = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (sel_ok) begin
            fwd    = 1'b1;
            fwd_ch = sel_idx[CH_W-1:0];
            ch_n   = sel_idx[CH_W-1:0];
            if (!s_axis.tlast[0]) state_n = ST_PKT;
          end else if (s_axis.tlast[0]) begin
            drop_inc = 1'b1;
          end else begin
            state_n = ST_DROP;
          end
        end
        ST_PKT: begin
          fwd = 1'b1;
          if (s_axis.tlast[0]) state_n = ST_IDLE;
        end
        ST_DROP: begin
          if (s_axis.tlast[0]) begin
            drop_inc = 1'b1;
            state_n  = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      ch_q     <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      ch_q  <= ch_n;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign in_payload = {fwd_ch, s_axis.tlast[0], s_axis.tdata[DATA_W-1:0]};

  axis_skid_buf #(.PAYLOAD_W(PAY_W)) u_buf (
    .clk         (aclk),
    .rst_n       (aresetn),
    .in_valid    (fwd),
    .in_payload  (in_payload),
    .in_ready    (buf_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_ready   (out_ready),
    .occupied    (buf_occupied)
  );

  assign main_ch   = out_payload[PAY_W-1 -: CH_W];
  assign main_last = out_payload[DATA_W];
  assign main_data = out_payload[DATA_W-1:0];

  always_comb begin
    m_valid   = '0;
    m_last    = '0;
    m_data    = '0;
    out_ready = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (out_valid && (main_ch == CH_W'(k))) begin
        m_valid[k]                 = 1'b1;
        m_last[k]                  = main_last;
        m_data[k*DATA_W +: DATA_W] = main_data;
        out_ready                  = m_axis.tready[k];
      end
    end
  end

  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdata  = m_data;
  assign busy = (state != ST_IDLE) | buf_occupied;

endmodule

// File: tb/tb_axis_demux_pkt.sv
// Bench for axis_demux_pkt: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a stall-mode instance.
module tb_axis_demux_pkt;

  localparam int NCH = 10;
  localparam int DW  = 32;

  typedef struct {
    int          ch;
    logic [31:0] data;
    bit          last;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [7:0]  a_sel = '0;
  logic [15:0] a_drop;
  logic        a_busy;
  logic [7:0]  b_sel = '0;
  logic [15:0] b_drop;
  logic        b_busy;

  axis_demux_pkt_if #(.N(1),   .DATA_W(DW)) a_s ();
  axis_demux_pkt_if #(.N(NCH), .DATA_W(DW)) a_m ();
  axis_demux_pkt_if #(.N(1),   .DATA_W(DW)) b_s ();
  axis_demux_pkt_if #(.N(NCH), .DATA_W(DW)) b_m ();

  axis_demux_pkt #(.NUM_CH(NCH), .DATA_W(DW), .DROP_INVALID(1'b1)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .bus_sel(a_sel),
    .s_axis(a_s), .m_axis(a_m), .drop_cnt(a_drop), .busy(a_busy)
  );

  axis_demux_pkt #(.NUM_CH(NCH), .DATA_W(DW), .DROP_INVALID(1'b0)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .bus_sel(b_sel),
    .s_axis(b_s), .m_axis(b_m), .drop_cnt(b_drop), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  beat_t mq[$];
  beat_t log_q[$];
  int    mode = 0;       // 0 between packets, 1 forwarding, 2 discarding
  int    lock_ch = 0;
  int    exp_drop = 0;
  bit    armed = 1'b0;
  bit    saw_low = 1'b0;
  bit    rdy_force = 1'b1;
  logic [NCH-1:0] rdy_val = '1;

  task automatic check_vec(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [7:0] sel, input logic [31:0] d, input bit last);
    beat_t b;
    int unsigned idx;
    idx = sel[6:0];
    if (mode == 0) begin
      if (sel[7] && idx < NCH) begin
        b.ch = int'(idx); b.data = d; b.last = last;
        mq.push_back(b);
        if (!last) begin mode = 1; lock_ch = int'(idx); end
      end else if (last) begin
        if (exp_drop < 65535) exp_drop++;
      end else begin
        mode = 2;
      end
    end else if (mode == 1) begin
      b.ch = lock_ch; b.data = d; b.last = last;
      mq.push_back(b);
      if (last) mode = 0;
    end else if (last) begin
      if (exp_drop < 65535) exp_drop++;
      mode = 0;
    end
  endtask

  // Compare process: outputs after each rising edge, then the handshakes of the next edge.
  always @(negedge aclk) begin
    logic [NCH-1:0]    ev, el;
    logic [NCH*DW-1:0] ed;
    beat_t             b;
    if (!aresetn) begin
      check_vec("rst_tvalid", a_m.tvalid, '0);
      check_vec("rst_tready", a_s.tready, '0);
      check_vec("rst_busy",   a_busy, '0);
      check_vec("rst_drop",   a_drop, '0);
      mq.delete();
      mode = 0; exp_drop = 0; armed = 1'b0;
    end else begin
      ev = '0; el = '0; ed = '0;
      if (mq.size() > 0) begin
        ev[mq[0].ch] = 1'b1;
        el[mq[0].ch] = mq[0].last;
        ed[mq[0].ch*DW +: DW] = mq[0].data;
      end
      check_vec("m_tvalid", a_m.tvalid, ev);
      check_vec("m_tlast",  a_m.tlast,  el);
      check_vec("m_tdata",  a_m.tdata,  ed);
      check_vec("s_tready", a_s.tready, (armed && mq.size() < 2) ? 1 : 0);
      check_vec("busy",     a_busy, (mode != 0 || mq.size() > 0) ? 1 : 0);
      check_vec("drop_cnt", a_drop, exp_drop);
      if (armed && !a_s.tready[0]) saw_low = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (a_m.tvalid[k] && a_m.tready[k]) begin
          b.ch = k; b.data = a_m.tdata[k*DW +: DW]; b.last = a_m.tlast[k];
          log_q.push_back(b);
        end
      end
      if (mq.size() > 0 && a_m.tready[mq[0].ch]) void'(mq.pop_front());
      if (a_s.tvalid[0] && a_s.tready[0]) model_accept(a_sel, a_s.tdata, a_s.tlast[0]);
      armed = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (rdy_force) a_m.tready = rdy_val;
      else for (int k = 0; k < NCH; k++) a_m.tready[k] = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic send_beat(input logic [7:0] sel, input logic [31:0] d, input bit last);
    bit acc;
    acc = 1'b0;
    a_sel = sel; a_s.tdata = d; a_s.tlast = last; a_s.tvalid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge aclk);
      acc = a_s.tready[0];
      @(posedge aclk); #1;
    end
    a_s.tvalid = 1'b0; a_s.tlast = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=stalled expected=accepted t=%0t", $time);
    end
  endtask

  task automatic send_pkt(input logic [7:0] sel0, input int len, input bit chg,
                          input int gap, input logic [31:0] base, input bit rnd);
    logic [7:0] s;
    for (int i = 0; i < len; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) step();
      s = (chg && i > 0) ? 8'($urandom) : sel0;
      send_beat(s, rnd ? 32'($urandom) : base + 32'(i), i == len - 1);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge aclk);
      idle = !a_busy && mq.size() == 0;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle t=%0t", $time);
    end
    step();
  endtask

  task automatic chk_entry(input string name, input int i, input int ch,
                           input logic [31:0] d, input bit last);
    if (i >= log_q.size()) begin
      checks++; errors++;
      $display("FAIL %s[%0d] actual=missing expected=ch%0d/%0h", name, i, ch, d);
    end else begin
      check_vec(name, {log_q[i].ch, log_q[i].last, log_q[i].data}, {ch, last, d});
    end
  endtask

  initial begin
    logic [7:0] sel;
    int r;
    a_s.tvalid = 1'b0; a_s.tlast = 1'b0; a_s.tdata = '0;
    b_s.tvalid = 1'b0; b_s.tlast = 1'b0; b_s.tdata = '0;
    a_m.tready = '0; b_m.tready = '1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Route: 0x83, four beats, first beat visible one cycle after acceptance.
    log_q.delete();
    send_beat(8'h83, 32'hA000_0000, 1'b0);
    @(negedge aclk);
    check_vec("route_lat_valid", a_m.tvalid, 10'h008);
    check_vec("route_lat_data", a_m.tdata[3*DW +: DW], 32'hA000_0000);
    step();
    for (int i = 1; i < 4; i++) send_beat(8'h83, 32'hA000_0000 + 32'(i), i == 3);
    wait_idle();
    check_vec("route_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_entry("route_beat", i, 3, 32'hA000_0000 + 32'(i), i == 3);

    // Lock: select changes mid-packet; next packet follows the new select.
    log_q.delete();
    send_beat(8'h83, 32'h1000_0000, 1'b0);
    for (int i = 1; i < 4; i++) send_beat(8'h85, 32'h1000_0000 + 32'(i), i == 3);
    send_pkt(8'h85, 2, 1'b0, 0, 32'h5000_0000, 1'b0);
    wait_idle();
    check_vec("lock_count", log_q.size(), 6);
    for (int i = 0; i < 4; i++) chk_entry("lock_ch3", i, 3, 32'h1000_0000 + 32'(i), i == 3);
    for (int i = 0; i < 2; i++) chk_entry("lock_ch5", 4 + i, 5, 32'h5000_0000 + 32'(i), i == 1);

    // Backpressure: ch2 ready withheld for three cycles mid-stream.
    log_q.delete();
    saw_low = 1'b0;
    fork
      send_pkt(8'h82, 6, 1'b0, 0, 32'hB000_0000, 1'b0);
      begin step(); step(); rdy_val = 10'h3FB; repeat (3) step(); rdy_val = '1; end
    join
    wait_idle();
    check_vec("bp_tready_fell", saw_low, 1);
    check_vec("bp_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++) chk_entry("bp_beat", i, 2, 32'hB000_0000 + 32'(i), i == 5);

    // Drop: out-of-range channel, then enable bit clear (single beat).
    log_q.delete();
    send_pkt(8'h8C, 3, 1'b0, 1, 32'hDEAD_0000, 1'b0);
    wait_idle();
    check_vec("drop_cnt_1", a_drop, 1);
    send_pkt(8'h05, 1, 1'b0, 0, 32'hDEAD_1000, 1'b0);
    wait_idle();
    check_vec("drop_cnt_2", a_drop, 2);
    check_vec("drop_no_output", log_q.size(), 0);

    // Random traffic with random downstream readiness.
    rdy_force = 1'b0;
    for (int p = 0; p < 150; p++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       sel = 8'h80 | 8'($urandom_range(0, NCH - 1));
      else if (r == 7) sel = 8'h80 | 8'($urandom_range(NCH, 127));
      else             sel = 8'($urandom_range(0, 127));
      send_pkt(sel, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 2, 32'h0, 1'b1);
    end
    rdy_force = 1'b1; rdy_val = '1;
    wait_idle();

    // Reset with both buffer entries full.
    rdy_val = '0;
    send_beat(8'h82, 32'hE000_0000, 1'b0);
    send_beat(8'h82, 32'hE000_0001, 1'b0);
    a_sel = 8'h82; a_s.tdata = 32'hE000_0002; a_s.tvalid = 1'b1;
    @(negedge aclk);
    check_vec("full_tready_low", a_s.tready, 0);
    check_vec("full_busy", a_busy, 1);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check_vec("rst_now_tvalid", a_m.tvalid, '0);
    check_vec("rst_now_tdata",  a_m.tdata, '0);
    check_vec("rst_now_tlast",  a_m.tlast, '0);
    check_vec("rst_now_tready", a_s.tready, '0);
    check_vec("rst_now_busy",   a_busy, '0);
    check_vec("rst_now_drop",   a_drop, '0);
    a_s.tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    rdy_val = '1;
    log_q.delete();
    send_pkt(8'h80, 2, 1'b0, 0, 32'hF000_0000, 1'b0);
    wait_idle();
    check_vec("post_rst_count", log_q.size(), 2);
    for (int i = 0; i < 2; i++) chk_entry("post_rst_beat", i, 0, 32'hF000_0000 + 32'(i), i == 1);

    // Stall mode: invalid select holds ready low until it becomes valid.
    b_sel = 8'h00; b_s.tdata = 32'hC0DE_0001; b_s.tlast = 1'b0; b_s.tvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check_vec("stall_tready", b_s.tready, 0);
    end
    step();
    b_sel = 8'h81;
    @(negedge aclk);
    check_vec("stall_release", b_s.tready, 1);
    step();
    b_s.tdata = 32'hC0DE_0002; b_s.tlast = 1'b1;
    @(negedge aclk);
    check_vec("stall_b0_valid", b_m.tvalid, 10'h002);
    check_vec("stall_b0_data", b_m.tdata[1*DW +: DW], 32'hC0DE_0001);
    check_vec("stall_pkt_ready", b_s.tready, 1);
    step();
    b_s.tvalid = 1'b0; b_s.tlast = 1'b0; b_sel = 8'h00;
    @(negedge aclk);
    check_vec("stall_b1_valid", b_m.tvalid, 10'h002);
    check_vec("stall_b1_data", b_m.tdata[1*DW +: DW], 32'hC0DE_0002);
    check_vec("stall_b1_last", b_m.tlast, 10'h002);
    step();
    @(negedge aclk);
    check_vec("stall_end_valid", b_m.tvalid, '0);
    check_vec("stall_end_busy", b_busy, 0);
    check_vec("stall_end_tready", b_s.tready, 0);
    check_vec("stall_no_drop", b_drop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/axis_demux_pkt.md
AXIS_DEMUX_PKT -- requirements
Module: axis_demux_pkt

Interface
REQ-001 The module SHALL take parameter NUM_CH, default 10, as the number of output channels (legal range 1..16).
REQ-002 The module SHALL take parameter DATA_W, default 32, as the tdata width in bits.
REQ-003 The module SHALL take parameter DROP_INVALID, default 1: 1 = discard packets with an invalid select, 0 = stall them.
REQ-004 aclk  in  1  single clock; all logic rising-edge.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 bus_sel  in  8  route select; bit7 = enable, bits[6:0] = channel index.
REQ-007 s_axis_tdata / s_axis_tvalid / s_axis_tlast  in  DATA_W/1/1  upstream stream.
REQ-008 s_axis_tready  out  1  upstream ready, driven from a register.
REQ-009 m_axis_tdata  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 m_axis_tvalid / m_axis_tlast  out  NUM_CH each  per-channel valid/last.
REQ-011 m_axis_tready  in  NUM_CH  per-channel downstream ready.
REQ-012 drop_cnt  out  16  count of dropped packets, saturating at 0xFFFF.
REQ-013 busy  out  1  high while a packet is locked (state != IDLE) or any buffer entry is valid.

Function
REQ-014 Select valid: bus_sel[7]=1 and bus_sel[6:0] < NUM_CH; any other value is invalid.
REQ-015 FSM states: IDLE, PKT, DROP.
REQ-016 IDLE: bus_sel is sampled on the first accepted beat, and that beat's channel is latched.
REQ-017 IDLE with a valid select and no tlast: transition to PKT.
REQ-018 IDLE with a valid select and tlast on the same beat: remain in IDLE.
REQ-019 PKT: bus_sel is ignored; all beats route to the latched channel; the FSM returns to IDLE on an accepted beat with tlast.
REQ-020 Invalid select, DROP_INVALID=1: beats are accepted with s_axis_tready=1, nothing is forwarded, the FSM moves to DROP, and returns to IDLE on tlast.
REQ-021 drop_cnt SHALL increment by 1 on the tlast of each dropped packet; a single-beat dropped packet counts once.
REQ-022 Invalid select, DROP_INVALID=0: s_axis_tready is held 0 in IDLE until bus_sel becomes valid.
REQ-023 Datapath: a 2-entry buffer (main + skid); each entry holds data, last and a channel index.
REQ-024 Latency: an accepted beat appears on m_axis_* exactly 1 cycle after acceptance when the main entry is empty or draining.
REQ-025 Output: only m_axis_tvalid[main.ch] may be 1; all other tvalid bits are 0, and unselected tdata lanes are 0.
REQ-026 An entry is consumed when m_axis_tvalid[ch] and m_axis_tready[ch] are both 1; the skid entry then moves to main in the same cycle.
REQ-027 s_axis_tready SHALL equal NOT(skid valid), registered.
REQ-028 Full throughput: a continuously ready channel sustains 1 beat per cycle.
REQ-029 Packet boundary: main and skid may hold different channels, and ordering across channels is preserved.
REQ-030 A beat is forwarded only once accepted; tvalid SHALL never drop without a handshake.
REQ-031 Readiness of a non-selected m_axis_tready SHALL have no effect.

Reset
REQ-032 While aresetn=0: FSM=IDLE, both entries invalid, all m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, drop_cnt=0, busy=0.
REQ-033 s_axis_tready SHALL rise 1 cycle after reset release.
REQ-034 Reset mid-packet SHALL discard buffered beats and the channel lock; the next accepted beat is treated as a packet start.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the SEL_EN_BIT=7 constant and the SEL_IDX_W=7 constant.
REQ-036 The 2-entry buffer SHALL be one sub-module, axis_skid_buf, parametrised by payload width.

Verification
REQ-037 Route: bus_sel=0x83, 4-beat packet, all ready -> beats on channel 3 only, first beat 1 cycle after acceptance, tlast on beat 4.
REQ-038 Lock: bus_sel changes 0x83->0x85 mid-packet -> whole packet on ch3; next packet on ch5.
REQ-039 Backpressure: m_axis_tready[2]=0 for 3 cycles during a ch2 stream -> s_axis_tready falls after 2 buffered beats; no loss or duplication; order intact.
REQ-040 Drop: DROP_INVALID=1, bus_sel=0x8C with NUM_CH=10 -> no m_axis_tvalid, drop_cnt 0->1; bus_sel=0x05 -> drop_cnt=2.
REQ-041 Stall: DROP_INVALID=0, bus_sel=0x00 -> s_axis_tready=0; set to 0x81 -> packet flows to ch1.
REQ-042 Reset: assert aresetn mid-packet with the skid full -> all outputs 0 immediately; after release, a new packet with bus_sel=0x80 routes to ch0.
